// File: rtl/flit_tx.sv
// flit_tx: credit-based flit transmitter (upstream end of a flit/credit link).
// Accepts packet descriptors, segments them into 22-bit staging flits and
// tracks per-VC downstream buffer credits returned on cr_in.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   desc_valid/ready  descriptor handshake (ready == idle == state IDLE)
//   desc_dest/vc/len  destination id, VC, packet length (0 treated as 1)
//   cr_in             credit return {valid, vc[4:0], stamp[15:0]}
//   flit_out          {valid, vc[4:0], head, tail, dest[13:0]}, registered
//   can_send          per-VC credit available
//   idle              no packet in progress
//   bad_desc          one-cycle pulse when a descriptor with bad VC is dropped
//   tx_count          flits sent since reset (wraps)
//   credit_err        sticky credit overflow flag (CREDIT_CHECK_EN only)
//
// Optional feature macro: CREDIT_CHECK_EN (saturating credits + credit_err).
module flit_tx #(
  parameter int NUM_VC    = 4,
  parameter int BUF_DEPTH = 1,
  parameter int LEN_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [13:0]       desc_dest,
  input  logic [4:0]        desc_vc,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic [21:0]       cr_in,
  output logic [21:0]       flit_out,
  output logic [NUM_VC-1:0] can_send,
  output logic              idle,
  output logic              bad_desc,
  output logic [15:0]       tx_count
`ifdef CREDIT_CHECK_EN
  ,
  output logic              credit_err
`endif
);

  localparam int CW = (BUF_DEPTH < 1) ? 1 : $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL     = CW'(BUF_DEPTH);
  localparam logic [5:0]    NUM_VC_W = 6'(NUM_VC);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [13:0]      dest_q;
  logic [4:0]       vc_q;
  logic [LEN_W-1:0] rem_q;
  logic             first_q;
  logic [CW-1:0]    credit [NUM_VC];

  logic [CW-1:0]     cur_credit;
  logic              send;
  logic              cr_ok;
  logic [NUM_VC-1:0] inc_v;
  logic [NUM_VC-1:0] dec_v;

  assign desc_ready = (state == IDLE);
  assign idle       = (state == IDLE);

  always_comb begin
    cur_credit = '0;
    can_send   = '0;
    inc_v      = '0;
    dec_v      = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (vc_q == 5'(v)) cur_credit = credit[v];
      can_send[v] = (credit[v] != '0);
    end
    // A send depends only on the pre-edge credit; same-edge returns don't help.
    send  = (state == SEND) && (cur_credit != '0);
    cr_ok = cr_in[21] && ({1'b0, cr_in[20:16]} < NUM_VC_W);
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      inc_v[v] = cr_ok && (cr_in[20:16] == 5'(v));
      dec_v[v] = send && (vc_q == 5'(v));
    end
  end

  // Credit counters: simultaneous return and send on one VC cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NUM_VC; v++) credit[v] <= FULL;
`ifdef CREDIT_CHECK_EN
      credit_err <= 1'b0;
`endif
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        case ({inc_v[v], dec_v[v]})
          2'b10: begin
`ifdef CREDIT_CHECK_EN
            if (credit[v] == FULL) credit_err <= 1'b1;
            else                   credit[v]  <= credit[v] + CW'(1);
`else
            credit[v] <= credit[v] + CW'(1);
`endif
          end
          2'b01:   credit[v] <= credit[v] - CW'(1);
          default: credit[v] <= credit[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dest_q   <= '0;
      vc_q     <= '0;
      rem_q    <= '0;
      first_q  <= 1'b0;
      flit_out <= '0;
      bad_desc <= 1'b0;
      tx_count <= '0;
    end else begin
      flit_out <= '0;
      bad_desc <= 1'b0;
      case (state)
        IDLE: begin
          if (desc_valid) begin
            if ({1'b0, desc_vc} < NUM_VC_W) begin
              dest_q  <= desc_dest;
              vc_q    <= desc_vc;
              rem_q   <= (desc_len == '0) ? LEN_W'(1) : desc_len;
              first_q <= 1'b1;
              state   <= SEND;
            end else begin
              bad_desc <= 1'b1;
            end
          end
        end
        SEND: begin
          if (send) begin
            flit_out <= {1'b1, vc_q, first_q, (rem_q == LEN_W'(1)), dest_q};
            rem_q    <= rem_q - LEN_W'(1);
            first_q  <= 1'b0;
            tx_count <= tx_count + 16'd1;
            if (rem_q == LEN_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_tx.sv
module tb_flit_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        desc_valid;
  logic        desc_ready;
  logic [13:0] desc_dest;
  logic [4:0]  desc_vc;
  logic [4:0]  desc_len;
  logic [21:0] cr_in;
  logic [21:0] flit_out;
  logic [3:0]  can_send;
  logic        idle;
  logic        bad_desc;
  logic [15:0] tx_count;
`ifdef CREDIT_CHECK_EN
  logic        credit_err;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  flit_tx #(.NUM_VC(4), .BUF_DEPTH(1), .LEN_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_dest(desc_dest), .desc_vc(desc_vc), .desc_len(desc_len),
    .cr_in(cr_in), .flit_out(flit_out), .can_send(can_send),
    .idle(idle), .bad_desc(bad_desc), .tx_count(tx_count)
`ifdef CREDIT_CHECK_EN
    , .credit_err(credit_err)
`endif
  );

  typedef struct {
    logic        dv;
    logic [13:0] dest;
    logic [4:0]  vc;
    logic [4:0]  len;
    logic [21:0] cr;
    logic [21:0] flit;
    logic [3:0]  cs;
    logic        idl;
    logic        bad;
    logic [15:0] tx;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  function automatic vec_t mk(logic dv, logic [13:0] dest, logic [4:0] vc,
                              logic [4:0] len, logic [21:0] cr,
                              logic [21:0] flit, logic [3:0] cs, logic idl,
                              logic bad, logic [15:0] tx);
    vec_t r;
    r.dv = dv; r.dest = dest; r.vc = vc; r.len = len; r.cr = cr;
    r.flit = flit; r.cs = cs; r.idl = idl; r.bad = bad; r.tx = tx;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [13:0] dest,
                       input logic [4:0] vc, input logic [4:0] len,
                       input logic [21:0] cr);
    desc_valid = dv; desc_dest = dest; desc_vc = vc; desc_len = len; cr_in = cr;
  endtask

  initial begin
    // idle/quiet vectors carry zero inputs; expectations hand-derived
    vt[0]  = mk(1, 14'h02A, 1, 1, 0,          22'h000000, 4'hF, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0,                22'h21C02A, 4'hD, 1, 0, 1);
    vt[2]  = mk(0, 0, 0, 0, 22'h210000,       22'h000000, 4'hF, 1, 0, 1);
    vt[3]  = mk(1, 14'h005, 0, 3, 0,          22'h000000, 4'hF, 0, 0, 1);
    vt[4]  = mk(0, 0, 0, 0, 0,                22'h208005, 4'hE, 0, 0, 2);
    vt[5]  = mk(0, 0, 0, 0, 0,                22'h000000, 4'hE, 0, 0, 2);
    vt[6]  = mk(0, 0, 0, 0, 22'h200000,       22'h000000, 4'hF, 0, 0, 2);
    vt[7]  = mk(0, 0, 0, 0, 0,                22'h200005, 4'hE, 0, 0, 3);
    vt[8]  = mk(0, 0, 0, 0, 22'h200000,       22'h000000, 4'hF, 0, 0, 3);
    vt[9]  = mk(0, 0, 0, 0, 0,                22'h204005, 4'hE, 1, 0, 4);
    vt[10] = mk(0, 0, 0, 0, 22'h200000,       22'h000000, 4'hF, 1, 0, 4);
    vt[11] = mk(1, 14'h001, 7, 1, 0,          22'h000000, 4'hF, 1, 1, 4);
    vt[12] = mk(0, 0, 0, 0, 0,                22'h000000, 4'hF, 1, 0, 4);
    vt[13] = mk(0, 0, 0, 0, 22'h290000,       22'h000000, 4'hF, 1, 0, 4);
    vt[14] = mk(1, 14'h3FFF, 3, 0, 0,         22'h000000, 4'hF, 0, 0, 4);
    vt[15] = mk(0, 0, 0, 0, 0,                22'h23FFFF, 4'h7, 1, 0, 5);
    vt[16] = mk(0, 0, 0, 0, 22'h230000,       22'h000000, 4'hF, 1, 0, 5);
    vt[17] = mk(1, 14'h000, 3, 2, 0,          22'h000000, 4'hF, 0, 0, 5);
    vt[18] = mk(1, 14'h001, 0, 1, 22'h230000, 22'h238000, 4'hF, 0, 0, 6);
    vt[19] = mk(0, 0, 0, 0, 0,                22'h234000, 4'h7, 1, 0, 7);
    vt[20] = mk(0, 0, 0, 0, 22'h230000,       22'h000000, 4'hF, 1, 0, 7);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst_flit", 32'(flit_out), 32'h0);
    chk("rst_can_send", 32'(can_send), 32'hF);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_ready", 32'(desc_ready), 32'h1);
    chk("rst_tx_count", 32'(tx_count), 32'h0);
    chk("rst_bad_desc", 32'(bad_desc), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].dv, vt[i].dest, vt[i].vc, vt[i].len, vt[i].cr);
      tick();
      chk($sformatf("v%0d_flit", i), 32'(flit_out), 32'(vt[i].flit));
      chk($sformatf("v%0d_can_send", i), 32'(can_send), 32'(vt[i].cs));
      chk($sformatf("v%0d_idle", i), 32'(idle), 32'(vt[i].idl));
      chk($sformatf("v%0d_ready", i), 32'(desc_ready), 32'(vt[i].idl));
      chk($sformatf("v%0d_bad_desc", i), 32'(bad_desc), 32'(vt[i].bad));
      chk($sformatf("v%0d_tx_count", i), 32'(tx_count), 32'(vt[i].tx));
    end
    drive(0, 0, 0, 0, 0);

    // credit return on a VC already at full credit
`ifdef CREDIT_CHECK_EN
    chk("no_err_before_ovf", 32'(credit_err), 32'h0);
`endif
    drive(0, 0, 0, 0, 22'h220000);
    tick();
`ifdef CREDIT_CHECK_EN
    chk("ovf_can_send", 32'(can_send), 32'hF);
    chk("ovf_err", 32'(credit_err), 32'h1);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("ovf_err_sticky", 32'(credit_err), 32'h1);
`else
    chk("ovf_wrap_can_send", 32'(can_send), 32'hB);
    drive(0, 0, 0, 0, 22'h220000);
    tick();
    chk("ovf_restore_can_send", 32'(can_send), 32'hF);
`endif
    drive(0, 0, 0, 0, 0);

    // reset in the middle of a packet abandons it
    drive(1, 14'h005, 0, 3, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("mid_head", 32'(flit_out), 32'h208005);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flit", 32'(flit_out), 32'h0);
    chk("mid_rst_idle", 32'(idle), 32'h1);
    chk("mid_rst_tx", 32'(tx_count), 32'h0);
    chk("mid_rst_can_send", 32'(can_send), 32'hF);
`ifdef CREDIT_CHECK_EN
    chk("mid_rst_err", 32'(credit_err), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_flit", 32'(flit_out), 32'h0);
    tick();
    chk("post_rst_no_tail", 32'(flit_out), 32'h0);
    chk("post_rst_idle", 32'(idle), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
